// File: rtl/pwr_seq_ctrl_multi.sv
// Multi-domain power-gating sequencer: one iso/ret/pse FSM per domain, with power-up
// serialised so at most one domain is ramping. Build with PWR_ACK_TIMEOUT_EN for ack timeouts.

module pwr_seq_dom #(
   parameter int DLY_W   = 8,
   parameter int DLY_CYC = 4,
   parameter int TO_CYC  = 64
) (
   input  logic clk,
   input  logic reset,
   input  logic sleep_req_i,
   input  logic pwr_ack_i,
   input  logic grant_i,
   output logic pse_o,
   output logic iso_o,
   output logic ret_o,
   output logic busy_o,
   output logic asleep_o,
   output logic err_o,
   output logic pup_o
);
   typedef enum logic [2:0] {S_ON, S_ISO, S_SAVE, S_PDN, S_OFF, S_PUP, S_RESTORE} state_t;

   localparam logic [DLY_W-1:0] DLY_LD = DLY_W'(DLY_CYC - 1);

   if (DLY_CYC < 1 || DLY_CYC > (2**DLY_W) - 1 || TO_CYC < 1) begin : g_bad_param
      $error("pwr_seq_dom: DLY_CYC/TO_CYC out of range");
   end

   state_t           state_q, state_d;
   logic [DLY_W-1:0] cnt_q, cnt_d;
   logic             err_q, err_d;
   logic             to_exp;
   logic             pse_q, iso_q, ret_q, busy_q, asleep_q;

`ifdef PWR_ACK_TIMEOUT_EN
   localparam int TO_W = $clog2(TO_CYC + 1);
   localparam logic [TO_W-1:0] TO_LD = TO_W'(TO_CYC - 1);
   logic [TO_W-1:0] to_q, to_d;
`endif

   always_comb begin
      state_d = state_q;
      err_d   = err_q;
`ifdef PWR_ACK_TIMEOUT_EN
      to_exp  = (to_q == '0);
`else
      to_exp  = 1'b0;
`endif
      case (state_q)
         S_ON:      if (sleep_req_i)              state_d = S_ISO;
         S_ISO:     if (cnt_q == '0)              state_d = S_SAVE;
         S_SAVE:    if (cnt_q == '0)              state_d = S_PDN;
         S_PDN:     if (!pwr_ack_i || to_exp)     state_d = S_OFF;
         S_OFF:     if (!sleep_req_i && grant_i)  state_d = S_PUP;
         S_PUP:     if (pwr_ack_i || to_exp)      state_d = S_RESTORE;
         S_RESTORE: if (cnt_q == '0)              state_d = S_ON;
         default:                                 state_d = S_ON;
      endcase
      // A timeout only counts as an error when the ack really never arrived.
      if ((state_q == S_PDN && pwr_ack_i && to_exp) || (state_q == S_PUP && !pwr_ack_i && to_exp))
         err_d = 1'b1;
      // Both counters reload on every state change, so each state sees a fresh count.
      cnt_d = (state_d != state_q) ? DLY_LD : ((cnt_q == '0) ? '0 : cnt_q - 1'b1);
`ifdef PWR_ACK_TIMEOUT_EN
      to_d  = (state_d != state_q) ? TO_LD : ((to_q == '0) ? '0 : to_q - 1'b1);
`endif
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= S_ON;
         cnt_q    <= '0;
         err_q    <= 1'b0;
         pse_q    <= 1'b1;
         iso_q    <= 1'b0;
         ret_q    <= 1'b0;
         busy_q   <= 1'b0;
         asleep_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         err_q    <= err_d;
         pse_q    <= !(state_d inside {S_PDN, S_OFF});
         iso_q    <= (state_d != S_ON);
         ret_q    <= (state_d inside {S_SAVE, S_PDN, S_OFF, S_PUP});
         busy_q   <= !(state_d inside {S_ON, S_OFF});
         asleep_q <= (state_d == S_OFF);
      end
   end

`ifdef PWR_ACK_TIMEOUT_EN
   always_ff @(posedge clk) begin
      if (reset) to_q <= '0;
      else       to_q <= to_d;
   end
   assign err_o = err_q;
`else
   assign err_o = 1'b0;
`endif

   assign pse_o    = pse_q;
   assign iso_o    = iso_q;
   assign ret_o    = ret_q;
   assign busy_o   = busy_q;
   assign asleep_o = asleep_q;
   assign pup_o    = (state_q == S_PUP);
endmodule

module pwr_seq_ctrl_multi #(
   parameter int N_DOM   = 4,
   parameter int DLY_W   = 8,
   parameter int DLY_CYC = 4,
   parameter int TO_CYC  = 64
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [N_DOM-1:0] sleep_req,
   input  logic [N_DOM-1:0] pwr_ack,
   output logic [N_DOM-1:0] pse,
   output logic [N_DOM-1:0] iso,
   output logic [N_DOM-1:0] ret,
   output logic [N_DOM-1:0] busy,
   output logic [N_DOM-1:0] asleep,
   output logic [N_DOM-1:0] err
);
   if (N_DOM < 1 || N_DOM > 16) begin : g_bad_ndom
      $error("pwr_seq_ctrl_multi: N_DOM out of range");
   end

   logic [N_DOM-1:0] pup, grant;
   logic             taken;

   // Lowest-index OFF domain asking to wake gets the single PUP slot, and only if it is free.
   always_comb begin
      grant = '0;
      taken = 1'b0;
      for (int i = 0; i < N_DOM; i++) begin
         grant[i] = !(|pup) && !taken;
         taken    = taken | (asleep[i] & ~sleep_req[i]);
      end
   end

   for (genvar g = 0; g < N_DOM; g++) begin : g_dom
      pwr_seq_dom #(.DLY_W(DLY_W), .DLY_CYC(DLY_CYC), .TO_CYC(TO_CYC)) u_dom (
         .clk        (clk),
         .reset      (reset),
         .sleep_req_i(sleep_req[g]),
         .pwr_ack_i  (pwr_ack[g]),
         .grant_i    (grant[g]),
         .pse_o      (pse[g]),
         .iso_o      (iso[g]),
         .ret_o      (ret[g]),
         .busy_o     (busy[g]),
         .asleep_o   (asleep[g]),
         .err_o      (err[g]),
         .pup_o      (pup[g])
      );
   end
endmodule

// File: tb/tb_pwr_seq_ctrl_multi.sv
// Randomised bench for pwr_seq_ctrl_multi against a timestamp-based reference model
// (each domain remembers its state name and the edge it entered it).

module tb_pwr_seq_ctrl_multi;
   localparam int N_DOM   = 4;
   localparam int DLY_W   = 8;
   localparam int DLY_CYC = 4;
   localparam int TO_CYC  = 64;
`ifdef PWR_ACK_TIMEOUT_EN
   localparam bit TO_EN = 1'b1;
`else
   localparam bit TO_EN = 1'b0;
`endif

   localparam int M_ON = 0, M_ISO = 1, M_SAVE = 2, M_PDN = 3, M_OFF = 4, M_PUP = 5, M_RES = 6;

   logic             clk = 1'b0;
   logic             reset;
   logic [N_DOM-1:0] sleep_req, pwr_ack;
   logic [N_DOM-1:0] pse, iso, ret, busy, asleep, err;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;
   int st  [N_DOM];
   int ent [N_DOM];
   bit er  [N_DOM];

   pwr_seq_ctrl_multi #(.N_DOM(N_DOM), .DLY_W(DLY_W), .DLY_CYC(DLY_CYC), .TO_CYC(TO_CYC)) dut (
      .clk      (clk),
      .reset    (reset),
      .sleep_req(sleep_req),
      .pwr_ack  (pwr_ack),
      .pse      (pse),
      .iso      (iso),
      .ret      (ret),
      .busy     (busy),
      .asleep   (asleep),
      .err      (err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, obs, exp);
      end
   endtask

   // Advance the model by one clock edge using the inputs visible at that edge.
   task automatic model_step();
      int  ns [N_DOM];
      bit  pup_busy, taken, tout;
      int  age;
      cyc++;
      pup_busy = 1'b0;
      for (int d = 0; d < N_DOM; d++) if (st[d] == M_PUP) pup_busy = 1'b1;
      taken = 1'b0;
      for (int d = 0; d < N_DOM; d++) begin
         ns[d] = st[d];
         age   = cyc - ent[d];
         tout  = TO_EN && (age == TO_CYC);
         case (st[d])
            M_ON:   if (sleep_req[d]) ns[d] = M_ISO;
            M_ISO:  if (age == DLY_CYC) ns[d] = M_SAVE;
            M_SAVE: if (age == DLY_CYC) ns[d] = M_PDN;
            M_PDN:  if (!pwr_ack[d]) ns[d] = M_OFF;
                    else if (tout) begin ns[d] = M_OFF; er[d] = 1'b1; end
            M_OFF:  if (!sleep_req[d]) begin
                       if (!pup_busy && !taken) ns[d] = M_PUP;
                       taken = 1'b1;
                    end
            M_PUP:  if (pwr_ack[d]) ns[d] = M_RES;
                    else if (tout) begin ns[d] = M_RES; er[d] = 1'b1; end
            default: if (age == DLY_CYC) ns[d] = M_ON;
         endcase
         if (reset) begin
            ns[d] = M_ON;
            er[d] = 1'b0;
         end
      end
      for (int d = 0; d < N_DOM; d++) begin
         if (ns[d] != st[d]) ent[d] = cyc;
         st[d] = ns[d];
      end
   endtask

   task automatic compare();
      logic [N_DOM-1:0] e_pse, e_iso, e_ret, e_busy, e_asl, e_err;
      for (int d = 0; d < N_DOM; d++) begin
         e_pse[d]  = !(st[d] == M_PDN || st[d] == M_OFF);
         e_iso[d]  = (st[d] != M_ON);
         e_ret[d]  = (st[d] == M_SAVE || st[d] == M_PDN || st[d] == M_OFF || st[d] == M_PUP);
         e_busy[d] = (st[d] != M_ON && st[d] != M_OFF);
         e_asl[d]  = (st[d] == M_OFF);
         e_err[d]  = er[d];
      end
      chk("pse",    32'(pse),    32'(e_pse));
      chk("iso",    32'(iso),    32'(e_iso));
      chk("ret",    32'(ret),    32'(e_ret));
      chk("busy",   32'(busy),   32'(e_busy));
      chk("asleep", 32'(asleep), 32'(e_asl));
      chk("err",    32'(err),    32'(e_err));
   endtask

   task automatic tick();
      @(posedge clk);
      model_step();
      #1;
      compare();
   endtask

   // Switch model: the rail tends to follow pse after a random lag, with occasional noise.
   task automatic drive_ack();
      int r;
      for (int d = 0; d < N_DOM; d++) begin
         r = $urandom_range(0, 9);
         if (r < 3)       pwr_ack[d] = pse[d];
         else if (r == 9) pwr_ack[d] = 1'($urandom_range(0, 1));
      end
   endtask

   initial begin
      for (int d = 0; d < N_DOM; d++) begin st[d] = M_ON; ent[d] = 0; er[d] = 1'b0; end
      reset = 1'b1; sleep_req = '0; pwr_ack = '1;
      repeat (3) begin @(negedge clk); tick(); end
      @(negedge clk); reset = 1'b0;

      // Free-running random traffic with rare mid-sequence resets.
      repeat (3000) begin
         for (int d = 0; d < N_DOM; d++)
            if ($urandom_range(0, 29) == 0) sleep_req[d] = ~sleep_req[d];
         drive_ack();
         reset = ($urandom_range(0, 499) == 0);
         tick();
         @(negedge clk);
      end
      reset = 1'b0;

      // Everyone asleep, then all wake at once to exercise the PUP grant.
      repeat (4) begin
         sleep_req = '1;
         repeat (150) begin drive_ack(); tick(); @(negedge clk); end
         sleep_req = '0;
         repeat (150) begin drive_ack(); tick(); @(negedge clk); end
      end

      // Rail stuck high while powering down: PDN stalls (or times out with the macro).
      sleep_req = '1; pwr_ack = '1;
      repeat (200) begin tick(); @(negedge clk); end
      // Rail stuck low while powering up.
      sleep_req = '0; pwr_ack = '0;
      repeat (400) begin tick(); @(negedge clk); end

      // Reset while sequences are in flight, then a final random stretch.
      reset = 1'b1; tick(); @(negedge clk); reset = 1'b0;
      repeat (1000) begin
         for (int d = 0; d < N_DOM; d++)
            if ($urandom_range(0, 19) == 0) sleep_req[d] = ~sleep_req[d];
         drive_ack();
         tick();
         @(negedge clk);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
